counter_checker: RTL and testbench
==================================

Name: counter_checker

Overview:
- Sequential self-checking monitor that consumes the two 8-bit counter streams and their "is one" flags, as produced by the team's dual-style counter.
- Checks every cycle that each stream advances by STEP modulo 2^W.
- Checks that each flag equals (value == FLAG_VAL).
- Counts and reports errors per channel, so benches can end on a checker verdict instead of waveform inspection.

Parameters:
- W, 8, counter value width
- STEP, 1, expected per-cycle increment (mod 2^W)
- FLAG_VAL, 1, value at which flag_* must be high
- CW, 16, width of error/sample counters (saturating)
- STOP_ON_ERR, 0, 1 = enter HALT on first error

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 at a rising clk edge resets)
- en  input  1  checking enable
- val_a  input  W  channel A count (non-blocking counter output)
- flag_a  input  1  channel A is-one flag
- val_b  input  W  channel B count (blocking counter output)
- flag_b  input  1  channel B is-one flag
- locked  output  1  high while in TRACK
- err_a  output  1  one-cycle pulse: channel A error detected
- err_b  output  1  one-cycle pulse: channel B error detected
- err_cnt_a  output  CW  saturating channel A error count
- err_cnt_b  output  CW  saturating channel B error count
- samples  output  CW  saturating count of checked cycles
- halted  output  1  high in HALT
- first_err_val  output  W  observed value at first error (A if both)
- first_err_ch  output  2  {B,A} mask of first error; 0 = none yet

Behaviour:
- All outputs registered.
- Reset (reset==0 at an edge):
  - state=IDLE.
  - All outputs 0, including counters, first_err_*, locked and halted.
  - exp_a/exp_b = 0.
  - Reset mid-operation aborts immediately; no pulse is emitted in the reset cycle.
- States:
  - IDLE: en=1 -> SYNC; else stay.
  - SYNC, one cycle:
    - Loads exp_a = val_a+STEP and exp_b = val_b+STEP. No value check.
    - Flags are checked against the sampled values.
    - -> TRACK; locked=1 from the next cycle.
  - TRACK, each cycle:
    - A-error = (val_a != exp_a) OR (flag_a != (val_a==FLAG_VAL)). B-error likewise on the B inputs.
    - A channel with both conditions counts once.
    - samples += 1.
  - HALT (STOP_ON_ERR=1 only):
    - Freezes all counters and first_err_*.
    - err_* = 0; locked=0; halted=1.
    - Exits only via reset.
- Latency: err_a/err_b pulse on the cycle after the offending sample.
- Resync after error: next exp = observed+STEP, never stale exp+STEP. A single glitch therefore gives exactly one error, not a cascade.
- Wrap-around: exp is computed mod 2^W. 8'hFF followed by 8'h00 (STEP=1) is legal.
- Saturation: err_cnt_* and samples stop at all-ones and never wrap.
- first_err_*:
  - Captured only while first_err_ch==0.
  - Simultaneous A and B errors give first_err_ch=2'b11 and first_err_val=val_a.
- en deassert:
  - In SYNC/TRACK: -> IDLE, locked=0. Counters and first_err_* are retained.
  - Re-enable goes through SYNC again, so no error is flagged across the gap.
- STOP_ON_ERR=1: an error in TRACK still pulses err_* and increments its count, then -> HALT.

Test Plan:
- Reset low 1 cycle, then en=1; both channels count 0,1,2…40 with flag high only at 1 -> locked=1 from cycle 2, err_cnt_a=err_cnt_b=0, samples=39, first_err_ch=0.
- Channels run 8'hFD..8'h03 through the wrap -> no errors; flags low throughout (FLAG_VAL=1 not crossed until 8'h01, where flag is high).
- Channel B skips 5 (…4,6,7,8…) -> exactly one err_b pulse, on the cycle after 6 is sampled; err_cnt_b=1; first_err_ch=2'b10; first_err_val=6; A unaffected.
- flag_a held high at val_a=2 and val_b=3 with a wrong B value in the same cycle -> err_a and err_b pulse together; first_err_ch=2'b11; first_err_val=2.
- en dropped for 3 cycles while the count jumps 10->20, then re-raised -> locked drops, resyncs via SYNC, zero new errors.
- STOP_ON_ERR=1: inject an error at val_a=7 -> halted=1, counters frozen at 1; pulse reset low -> all outputs return to 0.

Source files
------------

// File: rtl/counter_checker.sv
// -----------------------------------------------------------------------------
// counter_checker
//
// Self-checking monitor for the two streams of the dual-style counter. After a
// one-cycle SYNC, it checks every cycle that each value advances by STEP
// (mod 2^W) and that each "is one" flag matches (value == FLAG_VAL). It also
// keeps per-channel error counts, a count of checked cycles, and a snapshot of
// the first error. With STOP_ON_ERR=1 the first error freezes the checker in
// HALT until reset.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-low reset
//   en             checking enable
//   val_a, flag_a  channel A count and is-one flag
//   val_b, flag_b  channel B count and is-one flag
//   locked         high while tracking
//   err_a, err_b   one-cycle error pulses, one cycle after the bad sample
//   err_cnt_a/b    saturating per-channel error counts
//   samples        saturating count of checked (TRACK) cycles
//   halted         high in HALT
//   first_err_val  value observed at the first error (channel A if both)
//   first_err_ch   {B,A} mask of the first error, 0 until one occurs
// -----------------------------------------------------------------------------
module counter_checker #(
    parameter int W           = 8,
    parameter int STEP        = 1,
    parameter int FLAG_VAL    = 1,
    parameter int CW          = 16,
    parameter int STOP_ON_ERR = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [W-1:0]  val_a,
    input  logic          flag_a,
    input  logic [W-1:0]  val_b,
    input  logic          flag_b,
    output logic          locked,
    output logic          err_a,
    output logic          err_b,
    output logic [CW-1:0] err_cnt_a,
    output logic [CW-1:0] err_cnt_b,
    output logic [CW-1:0] samples,
    output logic          halted,
    output logic [W-1:0]  first_err_val,
    output logic [1:0]    first_err_ch
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [W-1:0] STEP_W = W'(STEP);
    localparam logic [W-1:0] FLAG_W = W'(FLAG_VAL);

    state_t       state;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;

    logic flag_bad_a, flag_bad_b;
    logic hit_a, hit_b;
    logic tracking;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (&c) ? c : c + CW'(1);
    endfunction

    assign flag_bad_a = flag_a != (val_a == FLAG_W);
    assign flag_bad_b = flag_b != (val_b == FLAG_W);
    assign tracking   = en && (state == TRACK);

    // SYNC only knows the flags are trustworthy; the value reference is not
    // established until the sample taken there.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        if (en && state == SYNC) begin
            hit_a = flag_bad_a;
            hit_b = flag_bad_b;
        end else if (tracking) begin
            hit_a = (val_a != exp_a) || flag_bad_a;
            hit_b = (val_b != exp_b) || flag_bad_b;
        end
    end

    // NOTE: state and outputs are registers, so they use non-blocking
    // assignments; every read in this block sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            exp_a         <= '0;
            exp_b         <= '0;
            locked        <= 1'b0;
            err_a         <= 1'b0;
            err_b         <= 1'b0;
            err_cnt_a     <= '0;
            err_cnt_b     <= '0;
            samples       <= '0;
            halted        <= 1'b0;
            first_err_val <= '0;
            first_err_ch  <= 2'b00;
        end else begin
            err_a <= hit_a;
            err_b <= hit_b;

            if (hit_a) err_cnt_a <= sat_inc(err_cnt_a);
            if (hit_b) err_cnt_b <= sat_inc(err_cnt_b);
            if (tracking) samples <= sat_inc(samples);

            if ((hit_a || hit_b) && first_err_ch == 2'b00) begin
                first_err_ch  <= {hit_b, hit_a};
                first_err_val <= hit_a ? val_a : val_b;
            end

            case (state)
                IDLE: begin
                    locked <= 1'b0;
                    if (en) state <= SYNC;
                end
                SYNC, TRACK: begin
                    if (!en) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end else begin
                        // Always rebase on the observed value so a single
                        // glitch costs one error instead of a cascade.
                        exp_a <= val_a + STEP_W;
                        exp_b <= val_b + STEP_W;
                        if ((hit_a || hit_b) && STOP_ON_ERR != 0) begin
                            state  <= HALT;
                            locked <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state  <= TRACK;
                            locked <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    locked <= 1'b0;
                    halted <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_checker.sv
module tb_counter_checker;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] val_a, val_b;
    logic       flag_a, flag_b;

    // Main instance: default parameters.
    logic        locked, err_a, err_b, halted;
    logic [15:0] err_cnt_a, err_cnt_b, samples;
    logic [7:0]  first_err_val;
    logic [1:0]  first_err_ch;

    // Halting instance: STOP_ON_ERR=1.
    logic        h_locked, h_err_a, h_err_b, h_halted;
    logic [15:0] h_err_cnt_a, h_err_cnt_b, h_samples;
    logic [7:0]  h_first_err_val;
    logic [1:0]  h_first_err_ch;

    // Narrow-counter instance: CW=2 to reach saturation quickly.
    logic        s_locked, s_err_a, s_err_b, s_halted;
    logic [1:0]  s_err_cnt_a, s_err_cnt_b, s_samples;
    logic [7:0]  s_first_err_val;
    logic [1:0]  s_first_err_ch;

    int total = 0;
    int bad   = 0;
    int pulses;

    counter_checker dut (
        .clk(clk), .reset(reset), .en(en),
        .val_a(val_a), .flag_a(flag_a), .val_b(val_b), .flag_b(flag_b),
        .locked(locked), .err_a(err_a), .err_b(err_b),
        .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b), .samples(samples),
        .halted(halted), .first_err_val(first_err_val), .first_err_ch(first_err_ch)
    );

    counter_checker #(.STOP_ON_ERR(1)) dut_h (
        .clk(clk), .reset(reset), .en(en),
        .val_a(val_a), .flag_a(flag_a), .val_b(val_b), .flag_b(flag_b),
        .locked(h_locked), .err_a(h_err_a), .err_b(h_err_b),
        .err_cnt_a(h_err_cnt_a), .err_cnt_b(h_err_cnt_b), .samples(h_samples),
        .halted(h_halted), .first_err_val(h_first_err_val), .first_err_ch(h_first_err_ch)
    );

    counter_checker #(.CW(2)) dut_s (
        .clk(clk), .reset(reset), .en(en),
        .val_a(val_a), .flag_a(flag_a), .val_b(val_b), .flag_b(flag_b),
        .locked(s_locked), .err_a(s_err_a), .err_b(s_err_b),
        .err_cnt_a(s_err_cnt_a), .err_cnt_b(s_err_cnt_b), .samples(s_samples),
        .halted(s_halted), .first_err_val(s_first_err_val), .first_err_ch(s_first_err_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [7:0] va;
        logic       fa;
        logic [7:0] vb;
        logic       fb;
        logic       x_err_a;
        logic       x_err_b;
        logic       x_locked;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic logic is_one(input logic [7:0] v);
        return v == 8'd1;
    endfunction

    // Drive one sample, then land 1 time unit after the capturing edge.
    task automatic cyc(input logic r, input logic e, input logic [7:0] va,
                       input logic fa, input logic [7:0] vb, input logic fb);
        reset  = r;
        en     = e;
        val_a  = va;
        flag_a = fa;
        val_b  = vb;
        flag_b = fb;
        @(posedge clk);
        #1;
    endtask

    task automatic good(input logic [7:0] v);
        cyc(1'b1, 1'b1, v, is_one(v), v, is_one(v));
        if (err_a || err_b) pulses++;
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            cyc(vecs[i].rst_n, vecs[i].en, vecs[i].va, vecs[i].fa, vecs[i].vb, vecs[i].fb);
            check($sformatf("row%0d_err_a", i), err_a, vecs[i].x_err_a);
            check($sformatf("row%0d_err_b", i), err_b, vecs[i].x_err_b);
            check($sformatf("row%0d_locked", i), locked, vecs[i].x_locked);
        end
    endtask

    initial begin
        //          rst  en  va     fa   vb     fb   ea   eb   lk
        // B skips 5, continuing from a TRACK run that ended at 3.
        vecs[0] = '{1'b1, 1'b1, 8'd4, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 8'd5, 1'b0, 8'd6, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 8'd6, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 8'd7, 1'b0, 8'd8, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 8'd8, 1'b0, 8'd9, 1'b0, 1'b0, 1'b0, 1'b1};
        // Reset, sync, then simultaneous A-flag and B-value errors.
        vecs[5] = '{1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 8'd2, 1'b1, 8'd3, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{1'b1, 1'b1, 8'd3, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b1};

        // ---- Reset state ----
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        check("reset_outputs",
              {locked, err_a, err_b, err_cnt_a, err_cnt_b, samples, halted, first_err_val, first_err_ch},
              64'd0);

        // ---- Clean count 0..40 ----
        pulses = 0;
        good(8'd0);
        check("p1_locked_idle_to_sync", locked, 1'b0);
        good(8'd1);
        check("p1_locked_after_sync", locked, 1'b1);
        for (int v = 2; v <= 40; v++) good(8'(v));
        check("p1_no_pulse", pulses, 0);
        check("p1_err_cnt_a", err_cnt_a, 16'd0);
        check("p1_err_cnt_b", err_cnt_b, 16'd0);
        check("p1_samples", samples, 16'd39);
        check("p1_first_err_ch", first_err_ch, 2'b00);
        check("p1_sat_samples", s_samples, 2'd3);

        // ---- Wrap-around FD..03 ----
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        pulses = 0;
        for (int v = 253; v <= 259; v++) good(8'(v));
        check("p2_no_pulse", pulses, 0);
        check("p2_err_cnt_a", err_cnt_a, 16'd0);
        check("p2_err_cnt_b", err_cnt_b, 16'd0);
        check("p2_samples", samples, 16'd5);

        // ---- B skips 5 ----
        apply_rows(0, 4);
        check("p3_err_cnt_a", err_cnt_a, 16'd0);
        check("p3_err_cnt_b", err_cnt_b, 16'd1);
        check("p3_first_err_ch", first_err_ch, 2'b10);
        check("p3_first_err_val", first_err_val, 8'd6);

        // ---- Simultaneous A and B errors ----
        apply_rows(5, 9);
        check("p4_first_err_ch", first_err_ch, 2'b11);
        check("p4_first_err_val", first_err_val, 8'd2);
        check("p4_err_cnt_a", err_cnt_a, 16'd1);
        check("p4_err_cnt_b", err_cnt_b, 16'd1);

        // ---- en gap while count jumps 10 -> 20 ----
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        pulses = 0;
        for (int v = 0; v <= 10; v++) good(8'(v));
        cyc(1'b1, 1'b0, 8'd13, 1'b0, 8'd13, 1'b0);
        check("p5_locked_drop", locked, 1'b0);
        cyc(1'b1, 1'b0, 8'd16, 1'b0, 8'd16, 1'b0);
        cyc(1'b1, 1'b0, 8'd20, 1'b0, 8'd20, 1'b0);
        check("p5_samples_retained", samples, 16'd9);
        good(8'd20);
        check("p5_locked_idle", locked, 1'b0);
        good(8'd21);
        check("p5_locked_resync", locked, 1'b1);
        for (int v = 22; v <= 25; v++) good(8'(v));
        check("p5_no_pulse", pulses, 0);
        check("p5_err_cnt_a", err_cnt_a, 16'd0);
        check("p5_err_cnt_b", err_cnt_b, 16'd0);
        check("p5_samples", samples, 16'd13);

        // ---- STOP_ON_ERR: flag error at val_a=7 ----
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        for (int v = 0; v <= 6; v++) good(8'(v));
        check("p6_h_locked_pre", h_locked, 1'b1);
        cyc(1'b1, 1'b1, 8'd7, 1'b1, 8'd7, 1'b0);
        check("p6_h_err_a", h_err_a, 1'b1);
        check("p6_h_halted", h_halted, 1'b1);
        check("p6_h_locked_halt", h_locked, 1'b0);
        check("p6_h_err_cnt_a", h_err_cnt_a, 16'd1);
        check("p6_h_samples", h_samples, 16'd6);
        cyc(1'b1, 1'b1, 8'd50, 1'b0, 8'd60, 1'b0);
        cyc(1'b1, 1'b1, 8'd51, 1'b1, 8'd61, 1'b0);
        check("p6_h_err_a_frozen", h_err_a, 1'b0);
        check("p6_h_err_cnt_a_frozen", h_err_cnt_a, 16'd1);
        check("p6_h_err_cnt_b_frozen", h_err_cnt_b, 16'd0);
        check("p6_h_samples_frozen", h_samples, 16'd6);
        check("p6_h_first", {h_first_err_ch, h_first_err_val}, {2'b01, 8'd7});
        check("p6_h_still_halted", h_halted, 1'b1);
        cyc(1'b0, 1'b1, 8'd52, 1'b0, 8'd62, 1'b0);
        check("p6_h_reset_outputs",
              {h_locked, h_err_a, h_err_b, h_err_cnt_a, h_err_cnt_b, h_samples, h_halted,
               h_first_err_val, h_first_err_ch},
              64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
